result_fifo: RTL and testbench
==============================

# result_fifo

Downstream stage of the `ula` polynomial unit: captures each finished 16-bit result when the unit's `valid` output rises and buffers it in a small first-word-fall-through FIFO. A consumer drains it through a valid/ready handshake. This decouples the multi-cycle `ula` from consumers that cannot accept a result on the exact cycle it appears. Overrun is detected and flagged rather than silently corrupting data.

## Interface
- `DEPTH`, 4: number of entries; power of two, ≥ 2.
- `WIDTH`, 16: data width; matches `ula` `result`.
- `CW`, $clog2(DEPTH)+1: width of `count`.

Ports:
- `clock` in 1: single clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-high.
- `result` in WIDTH: `ula` result bus.
- `valid` in 1: `ula` valid; may stay high for several cycles per result.
- `out_data` out WIDTH: head entry; forced to 0 when empty.
- `out_valid` out 1: FIFO non-empty.
- `out_ready` in 1: consumer accepts the head entry this cycle.
- `count` out CW: number of stored entries, 0..DEPTH.
- `full` out 1: `count == DEPTH`.
- `empty` out 1: `count == 0`.
- `overflow` out 1: sticky; a capture was dropped because the FIFO was full.

## Operation
- Edge detect: register `valid_q <= valid`. Capture event `cap = valid & ~valid_q`. There is exactly one capture per low→high transition of `valid`. A held-high `valid` produces no further captures.
- Push: on `cap`, write `result` at `wr_ptr` and set `wr_ptr <= wr_ptr+1` (mod DEPTH). Push only if `!full`, or if `full` and a pop occurs in the same cycle.
- Pop: `out_valid & out_ready` advances `rd_ptr` (mod DEPTH). `out_ready` while empty is ignored.
- Simultaneous push and pop: both occur and `count` is unchanged. This holds at full (the slot is freed) and at empty+1. At empty, a pop is impossible, so only the push occurs.
- Drop: `cap & full & ~(out_valid & out_ready)`. Data is discarded, pointers and count are unchanged, and `overflow <= 1`. `overflow` clears only on reset.
- `out_data = empty ? 0 : mem[rd_ptr]` is combinational from registered state. `out_valid = ~empty`. `full`/`empty` are derived from the registered `count`.
- Occupancy states: EMPTY (count 0) → PARTIAL → FULL (count DEPTH).
  - A push increments count and a pop decrements it.
  - Pointers wrap silently. Count never exceeds DEPTH and never goes below 0.
- Storage array is not reset. Correctness relies on the pointers and count only.

## Timing
- Reset (synchronous, takes priority over everything): `valid_q=0`, `wr_ptr=rd_ptr=0`, `count=0`. Therefore `empty=1`, `full=0`, `out_valid=0`, `out_data=0`, `overflow=0`.
- Reset mid-operation: all buffered entries are discarded in the reset cycle. No pop or push takes effect in that cycle.
- If `valid=1` on the first cycle after reset deasserts, it counts as a rising edge (`valid_q` is 0) and is captured.
- Latency:
  - A capture at edge N makes `out_valid=1` and `out_data=result` visible after edge N (cycle N+1). Zero bubbles are added beyond that one register.
  - A pop at edge N presents the next entry, or `out_valid=0`, after edge N.
- Throughput: one push and one pop per cycle.
- Handshake: `out_data` is stable while `out_valid=1 & out_ready=0`.

## Test plan
- Reset, then `valid` 0→1 with `result=39` (x=a=b=c=3) held for 3 cycles. Expected: exactly one entry, `count=1`, `out_data=39`, `out_valid=1` one cycle after the edge.
- Four pulses with results 10, 20, 30, 40 and `out_ready=0`. Expected: `full=1`, `count=4`. A fifth pulse (50) sets `overflow=1` and count stays 4. Draining yields 10, 20, 30, 40, then `empty=1` and `out_data=0`.
- FIFO full (10..40), fifth pulse (50) in the same cycle as `out_ready=1`. Expected: 10 popped, 50 accepted, `count=4`, `overflow=0`. Drain order is 20, 30, 40, 50.
- `out_ready=1` held, with 7 pulses spaced 2 cycles apart (values 1..7). Expected: each value emerges in order one cycle after capture, `count` never exceeds 1, and the pointers wrap past DEPTH correctly.
- Three entries stored, `overflow=1`; assert `reset` for one cycle. Expected: next cycle `count=0`, `empty=1`, `out_valid=0`, `out_data=0`, `overflow=0`.
- `valid` held high across reset deassertion with `result=7`. Expected: exactly one capture of 7 after reset and no recapture until `valid` falls and rises again.

Source files
------------

// File: rtl/result_fifo_if.sv
// Bundle of result_fifo signals: the ula-facing capture inputs
// and the consumer-facing valid/ready drain port with status flags.
interface result_fifo_if #(
  parameter int WIDTH = 16,
  parameter int CW    = 3
);
  logic [WIDTH-1:0] result;
  logic             valid;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [CW-1:0]    count;
  logic             full;
  logic             empty;
  logic             overflow;

  // FIFO side
  modport slave (
    input  result, valid, out_ready,
    output out_data, out_valid, count, full, empty, overflow
  );

  // Producer/consumer side
  modport master (
    output result, valid, out_ready,
    input  out_data, out_valid, count, full, empty, overflow
  );
endinterface

// File: rtl/result_fifo.sv
// result_fifo: captures one ula result per rising edge of valid into a
// first-word-fall-through FIFO, drained through a valid/ready handshake.
// A capture arriving while full (with no simultaneous pop) is dropped and
// latches a sticky overflow flag.
module result_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input logic          clock,
  input logic          reset,
  result_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  // Storage is deliberately not reset; pointers and count define validity.
  logic [WIDTH-1:0] mem [DEPTH];

  logic          valid_q, valid_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;

  logic cap, push, pop, drop, empty, full;

  // Edge detect, push/pop/drop decisions and next-state computation
  always_comb begin
    empty = (count_q == '0);
    full  = (count_q == CW'(DEPTH));
    cap   = bus.valid & ~valid_q;
    pop   = ~empty & bus.out_ready;
    // A full FIFO can still accept when the head leaves in the same cycle.
    push  = cap & (~full | pop);
    drop  = cap & full & ~pop;

    valid_d    = bus.valid;
    wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    overflow_d = overflow_q | drop;

    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // State registers; reset discards all buffered entries
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q    <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage write on accepted capture
  always_ff @(posedge clock) begin
    if (!reset && push) begin
      mem[wr_ptr_q] <= bus.result;
    end
  end

  // Fall-through head and status outputs from registered state
  always_comb begin
    bus.out_data  = empty ? '0 : mem[rd_ptr_q];
    bus.out_valid = ~empty;
    bus.count     = count_q;
    bus.full      = full;
    bus.empty     = empty;
    bus.overflow  = overflow_q;
  end
endmodule

// File: tb/tb_result_fifo.sv
// Self-checking bench for result_fifo: a queue scoreboard predicts the
// FIFO contents as captures are driven; pops are compared against it.
module tb_result_fifo;
  localparam int DEPTH = 4;
  localparam int WIDTH = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic clock;
  logic reset;

  result_fifo_if #(.WIDTH(WIDTH), .CW(CW)) bus ();

  result_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH), .CW(CW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int pass_cnt  = 0;
  int check_cnt = 0;

  logic [WIDTH-1:0] exp_q[$];
  logic             m_valid_q;
  logic             m_overflow;

  // Hold reset for n cycles with the given valid/result; clear the model.
  task automatic do_reset(input int n, input logic v, input logic [WIDTH-1:0] r);
    reset = 1'b1;
    bus.valid = v;
    bus.result = r;
    bus.out_ready = 1'b0;
    repeat (n) @(negedge clock);
    reset = 1'b0;
    exp_q.delete();
    m_valid_q  = 1'b0;
    m_overflow = 1'b0;
  endtask

  // Drive one cycle at the negedge, update the scoreboard, sample the head
  // before the edge and return what the model expects to pop.
  task automatic drive(input logic v, input logic [WIDTH-1:0] r, input logic rdy,
                       output logic popped, output logic [WIDTH-1:0] exp_d,
                       output logic [WIDTH-1:0] got_d);
    logic cap;
    bus.valid = v;
    bus.result = r;
    bus.out_ready = rdy;
    cap = v & ~m_valid_q;
    popped = rdy && (exp_q.size() > 0);
    exp_d = '0;
    got_d = bus.out_data;
    if (popped) exp_d = exp_q.pop_front();
    if (cap) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(r);
      else m_overflow = 1'b1;
    end
    m_valid_q = v;
    @(negedge clock);
  endtask

  task automatic test_reset();
    do_reset(2, 1'b0, '0);
    check_cnt++; if (bus.count !== '0) $display("FAIL rst_count: got %0d expected 0", bus.count); else pass_cnt++;
    check_cnt++; if (bus.empty !== 1'b1) $display("FAIL rst_empty: got %b expected 1", bus.empty); else pass_cnt++;
    check_cnt++; if (bus.full !== 1'b0) $display("FAIL rst_full: got %b expected 0", bus.full); else pass_cnt++;
    check_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b expected 0", bus.out_valid); else pass_cnt++;
    check_cnt++; if (bus.out_data !== '0) $display("FAIL rst_out_data: got %0d expected 0", bus.out_data); else pass_cnt++;
    check_cnt++; if (bus.overflow !== 1'b0) $display("FAIL rst_overflow: got %b expected 0", bus.overflow); else pass_cnt++;
    $display("test_reset done: count=%0d empty=%b", bus.count, bus.empty);
  endtask

  task automatic test_single_capture();
    logic p; logic [WIDTH-1:0] e, g;
    drive(1'b1, 16'd39, 1'b0, p, e, g);
    check_cnt++; if (bus.out_valid !== 1'b1) $display("FAIL single_out_valid: got %b expected 1", bus.out_valid); else pass_cnt++;
    check_cnt++; if (bus.out_data !== 16'd39) $display("FAIL single_out_data: got %0d expected 39", bus.out_data); else pass_cnt++;
    drive(1'b1, 16'd39, 1'b0, p, e, g);
    drive(1'b1, 16'd39, 1'b0, p, e, g);
    check_cnt++; if (bus.count !== CW'(1)) $display("FAIL single_held_count: got %0d expected 1", bus.count); else pass_cnt++;
    drive(1'b0, '0, 1'b1, p, e, g);
    check_cnt++; if (!p || g !== 16'd39) $display("FAIL single_pop: got %0d expected 39", g); else pass_cnt++;
    check_cnt++; if (bus.empty !== 1'b1) $display("FAIL single_empty: got %b expected 1", bus.empty); else pass_cnt++;
    $display("test_single_capture done: popped %0d", g);
  endtask

  task automatic test_overflow();
    logic p; logic [WIDTH-1:0] e, g;
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, WIDTH'(i * 10), 1'b0, p, e, g);
      drive(1'b0, '0, 1'b0, p, e, g);
    end
    check_cnt++; if (bus.full !== 1'b1) $display("FAIL ovf_full: got %b expected 1", bus.full); else pass_cnt++;
    check_cnt++; if (bus.count !== CW'(4)) $display("FAIL ovf_count_full: got %0d expected 4", bus.count); else pass_cnt++;
    drive(1'b1, 16'd50, 1'b0, p, e, g);
    drive(1'b0, '0, 1'b0, p, e, g);
    check_cnt++; if (bus.overflow !== 1'b1) $display("FAIL ovf_flag: got %b expected 1", bus.overflow); else pass_cnt++;
    check_cnt++; if (bus.count !== CW'(4)) $display("FAIL ovf_count_drop: got %0d expected 4", bus.count); else pass_cnt++;
    check_cnt++; if (bus.out_data !== 16'd10) $display("FAIL ovf_head_stable: got %0d expected 10", bus.out_data); else pass_cnt++;
    for (int k = 0; k < 2 * DEPTH && exp_q.size() > 0; k++) begin
      drive(1'b0, '0, 1'b1, p, e, g);
      check_cnt++; if (g !== e) $display("FAIL ovf_drain: got %0d expected %0d", g, e); else pass_cnt++;
      $display("ovf drain pop %0d", g);
    end
    check_cnt++; if (bus.empty !== 1'b1 || bus.out_data !== '0) $display("FAIL ovf_drained: got empty=%b data=%0d expected empty=1 data=0", bus.empty, bus.out_data); else pass_cnt++;
    check_cnt++; if (bus.overflow !== 1'b1) $display("FAIL ovf_sticky: got %b expected 1", bus.overflow); else pass_cnt++;
  endtask

  task automatic test_full_push_pop();
    logic p; logic [WIDTH-1:0] e, g;
    do_reset(1, 1'b0, '0);
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, WIDTH'(i * 10), 1'b0, p, e, g);
      drive(1'b0, '0, 1'b0, p, e, g);
    end
    drive(1'b1, 16'd50, 1'b1, p, e, g);
    check_cnt++; if (g !== 16'd10) $display("FAIL fpp_pop_head: got %0d expected 10", g); else pass_cnt++;
    check_cnt++; if (bus.count !== CW'(4)) $display("FAIL fpp_count: got %0d expected 4", bus.count); else pass_cnt++;
    check_cnt++; if (bus.overflow !== 1'b0) $display("FAIL fpp_overflow: got %b expected 0", bus.overflow); else pass_cnt++;
    for (int k = 0; k < 2 * DEPTH && exp_q.size() > 0; k++) begin
      drive(1'b0, '0, 1'b1, p, e, g);
      check_cnt++; if (g !== e) $display("FAIL fpp_drain: got %0d expected %0d", g, e); else pass_cnt++;
      $display("fpp drain pop %0d", g);
    end
    check_cnt++; if (bus.empty !== 1'b1) $display("FAIL fpp_empty: got %b expected 1", bus.empty); else pass_cnt++;
  endtask

  task automatic test_streaming();
    logic p; logic [WIDTH-1:0] e, g;
    for (int v = 1; v <= 7; v++) begin
      drive(1'b1, WIDTH'(v), 1'b1, p, e, g);
      check_cnt++; if (bus.out_valid !== 1'b1 || bus.out_data !== WIDTH'(v)) $display("FAIL stream_head: got valid=%b data=%0d expected valid=1 data=%0d", bus.out_valid, bus.out_data, v); else pass_cnt++;
      check_cnt++; if (bus.count !== CW'(1)) $display("FAIL stream_count: got %0d expected 1", bus.count); else pass_cnt++;
      drive(1'b0, '0, 1'b1, p, e, g);
      check_cnt++; if (!p || g !== e) $display("FAIL stream_pop: got %0d expected %0d", g, e); else pass_cnt++;
      $display("stream value %0d popped %0d", v, g);
    end
    check_cnt++; if (bus.count !== '0) $display("FAIL stream_final_count: got %0d expected 0", bus.count); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic p; logic [WIDTH-1:0] e, g;
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, WIDTH'(i), 1'b0, p, e, g);
      drive(1'b0, '0, 1'b0, p, e, g);
    end
    drive(1'b0, '0, 1'b1, p, e, g);
    bus.out_ready = 1'b0;
    check_cnt++; if (bus.count !== CW'(3) || bus.overflow !== 1'b1) $display("FAIL mid_setup: got count=%0d ovf=%b expected count=3 ovf=1", bus.count, bus.overflow); else pass_cnt++;
    do_reset(1, 1'b0, '0);
    check_cnt++; if (bus.count !== '0 || bus.empty !== 1'b1) $display("FAIL mid_count: got count=%0d empty=%b expected 0/1", bus.count, bus.empty); else pass_cnt++;
    check_cnt++; if (bus.out_valid !== 1'b0 || bus.out_data !== '0) $display("FAIL mid_out: got valid=%b data=%0d expected 0/0", bus.out_valid, bus.out_data); else pass_cnt++;
    check_cnt++; if (bus.overflow !== 1'b0) $display("FAIL mid_overflow: got %b expected 0", bus.overflow); else pass_cnt++;
    $display("test_reset_mid done: count=%0d", bus.count);
  endtask

  task automatic test_valid_held_reset();
    logic p; logic [WIDTH-1:0] e, g;
    do_reset(2, 1'b1, 16'd7);
    check_cnt++; if (bus.count !== '0) $display("FAIL held_in_reset: got %0d expected 0", bus.count); else pass_cnt++;
    drive(1'b1, 16'd7, 1'b0, p, e, g);
    check_cnt++; if (bus.count !== CW'(1) || bus.out_data !== 16'd7) $display("FAIL held_capture: got count=%0d data=%0d expected 1/7", bus.count, bus.out_data); else pass_cnt++;
    repeat (3) drive(1'b1, 16'd7, 1'b0, p, e, g);
    check_cnt++; if (bus.count !== CW'(1)) $display("FAIL held_no_recapture: got %0d expected 1", bus.count); else pass_cnt++;
    drive(1'b0, '0, 1'b0, p, e, g);
    drive(1'b1, 16'd8, 1'b0, p, e, g);
    check_cnt++; if (bus.count !== CW'(2)) $display("FAIL held_recapture: got %0d expected 2", bus.count); else pass_cnt++;
    for (int k = 0; k < 2 * DEPTH && exp_q.size() > 0; k++) begin
      drive(1'b0, '0, 1'b1, p, e, g);
      check_cnt++; if (g !== e) $display("FAIL held_drain: got %0d expected %0d", g, e); else pass_cnt++;
      $display("held drain pop %0d", g);
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.valid = 1'b0;
    bus.result = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_single_capture();
    test_overflow();
    test_full_push_pop();
    test_streaming();
    test_reset_mid();
    test_valid_held_reset();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

  // Absolute time limit so the run always terminates
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish before limit");
    $fatal(1, "timeout");
  end
endmodule
